// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_pkg
// Description : Shared fetch-stage types, FSM encodings and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_stage_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam logic [WORD_W-1:0] NOP_ENC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage_if
// Description : Control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_stage_if;
    import if_id_stage_pkg::*;

    logic              Stall;
    logic              Redirect;
    logic [WORD_W-1:0] RedirectTarget;
    logic [WORD_W-1:0] IMemData;
    logic [WORD_W-1:0] IMemAddr;
    logic [WORD_W-1:0] IDU_Instruction;
    logic [WORD_W-1:0] IDU_PCPlus4;
    logic              IDU_Valid;
    logic [15:0]       StallCycles;
    logic [15:0]       FlushCount;

    modport master (
        output Stall, Redirect, RedirectTarget, IMemData,
        input  IMemAddr, IDU_Instruction, IDU_PCPlus4, IDU_Valid,
               StallCycles, FlushCount
    );

    modport slave (
        input  Stall, Redirect, RedirectTarget, IMemData,
        output IMemAddr, IDU_Instruction, IDU_PCPlus4, IDU_Valid,
               StallCycles, FlushCount
    );
endinterface
`default_nettype wire

// File: rtl/if_id_stage_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Fetch PC register with +4 incrementer, hold and word-aligned load.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
    import if_id_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              hold,
    input  wire logic              load,
    input  wire logic [WORD_W-1:0] target,
    output logic      [WORD_W-1:0] pc,
    output logic      [WORD_W-1:0] pc_plus4
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    // Incrementer wraps naturally modulo 2^32.
    assign pc_plus4 = pc_q + 32'd4;
    assign pc       = pc_q;

    always_comb begin
        pc_d = pc_plus4;
        if (load) begin
            pc_d = target & ~32'h0000_0003;
        end else if (hold) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : Instruction fetch and IF/ID pipeline register with stall/redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    if_id_stage_if.slave  bus
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pcp4_q, pcp4_d;
    logic              valid_q, valid_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [15:0]       flush_cnt_q, flush_cnt_d;

    logic              pc_hold;
    logic              pc_load;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (Clk),
        .rst      (Reset),
        .hold     (pc_hold),
        .load     (pc_load),
        .target   (bus.RedirectTarget),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_hold     = 1'b0;
        pc_load     = 1'b0;

        case (state_q)
            ST_BOOT, ST_RUN, ST_HOLD: begin
                if (bus.Redirect) begin
                    // Redirect wins over Stall and squashes the fetch in flight.
                    pc_load     = 1'b1;
                    instr_d     = NOP_INSTR;
                    pcp4_d      = '0;
                    valid_d     = 1'b0;
                    flush_cnt_d = sat_inc16(flush_cnt_q);
                    state_d     = ST_RUN;
                end else if (bus.Stall && (state_q != ST_BOOT)) begin
                    pc_hold     = 1'b1;
                    stall_cnt_d = sat_inc16(stall_cnt_q);
                    state_d     = ST_HOLD;
                end else begin
                    instr_d     = bus.IMemData;
                    pcp4_d      = pc_plus4;
                    valid_d     = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_BOOT;
            instr_q     <= NOP_INSTR;
            pcp4_q      <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.IMemAddr        = pc;
    assign bus.IDU_Instruction = instr_q;
    assign bus.IDU_PCPlus4     = pcp4_q;
    assign bus.IDU_Valid       = valid_q;
    assign bus.StallCycles     = stall_cnt_q;
    assign bus.FlushCount      = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_stage
// Description : Directed self-checking bench for if_id_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    if_id_stage_if bus ();

    if_id_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (C_NOP)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'h2008_0005 : {16'hC0DE, addr[15:0]};
    endfunction

    assign bus.IMemData = mem_word(bus.IMemAddr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pcp4, input logic valid,
                             input logic [15:0] stalls, input logic [15:0] flushes);
        check_eq({tag, ".addr"},   bus.IMemAddr,        addr);
        check_eq({tag, ".instr"},  bus.IDU_Instruction, instr);
        check_eq({tag, ".pcp4"},   bus.IDU_PCPlus4,     pcp4);
        check_eq({tag, ".valid"},  {31'd0, bus.IDU_Valid}, {31'd0, valid});
        check_eq({tag, ".stalls"}, {16'd0, bus.StallCycles}, {16'd0, stalls});
        check_eq({tag, ".flush"},  {16'd0, bus.FlushCount},  {16'd0, flushes});
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        Reset              = 1'b1;
        bus.Stall          = 1'b0;
        bus.Redirect       = 1'b0;
        bus.RedirectTarget = 32'h0;

        step();
        step();
        check_all("reset", 32'h0, C_NOP, 32'h0, 1'b0, 16'd0, 16'd0);

        Reset = 1'b0;
        step();
        check_all("boot", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 16'd0, 16'd0);
        step();
        check_all("run4", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1, 16'd0, 16'd0);

        // Three stalled cycles at PC=8.
        bus.Stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq("stall.addr",  bus.IMemAddr,        32'h8);
            check_eq("stall.instr", bus.IDU_Instruction, 32'hC0DE_0004);
            check_eq("stall.pcp4",  bus.IDU_PCPlus4,     32'h8);
            check_eq("stall.cnt",   {16'd0, bus.StallCycles}, i);
        end
        bus.Stall = 1'b0;
        step();
        check_all("release", 32'hC, 32'hC0DE_0008, 32'hC, 1'b1, 16'd3, 16'd0);

        // Redirect together with Stall: redirect wins, no stall counted.
        bus.Stall          = 1'b1;
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 32'h0000_0043;
        step();
        check_all("redir", 32'h40, C_NOP, 32'h0, 1'b0, 16'd3, 16'd1);
        bus.Stall    = 1'b0;
        bus.Redirect = 1'b0;
        step();
        check_all("after_redir", 32'h44, 32'hC0DE_0040, 32'h44, 1'b1, 16'd3, 16'd1);

        // PC wrap at the top of the address space.
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 32'hFFFF_FFFF;
        step();
        check_eq("wrap.addr_top", bus.IMemAddr, 32'hFFFF_FFFC);
        bus.Redirect = 1'b0;
        step();
        check_all("wrap", 32'h0, 32'hC0DE_FFFC, 32'h0, 1'b1, 16'd3, 16'd2);

        // Long stall: counter saturates at 16'hFFFF.
        bus.Stall = 1'b1;
        repeat (65531) @(posedge Clk);
        #1;
        check_eq("sat.before", {16'd0, bus.StallCycles}, 32'h0000_FFFE);
        repeat (4469) @(posedge Clk);
        #1;
        check_eq("sat.hold", {16'd0, bus.StallCycles}, 32'h0000_FFFF);
        check_eq("sat.addr", bus.IMemAddr, 32'h0);

        // Asynchronous reset pulse between edges while in HOLD.
        #3;
        Reset = 1'b1;
        #1;
        check_all("async_rst", 32'h0, C_NOP, 32'h0, 1'b0, 16'd0, 16'd0);
        #2;
        Reset     = 1'b0;
        bus.Stall = 1'b0;
        step();
        check_all("reboot", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 16'd0, 16'd0);

        // Redirect during BOOT (Stall ignored, redirect honoured).
        Reset = 1'b1;
        step();
        Reset              = 1'b0;
        bus.Stall          = 1'b1;
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 32'h0000_0100;
        step();
        check_all("boot_redir", 32'h100, C_NOP, 32'h0, 1'b0, 16'd0, 16'd1);
        bus.Stall    = 1'b0;
        bus.Redirect = 1'b0;
        step();
        check_all("boot_redir_run", 32'h104, 32'hC0DE_0100, 32'h104, 1'b1, 16'd0, 16'd1);

        // Stall directly after BOOT with Stall held high during BOOT.
        Reset = 1'b1;
        step();
        Reset     = 1'b0;
        bus.Stall = 1'b1;
        step();
        check_all("boot_ign_stall", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 16'd0, 16'd0);
        step();
        check_all("stall_after_boot", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 16'd1, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
